// File: rtl/axi_zvc_mem_slave_if.sv
// AXI4 bus bundle for the zero-value-compressing line memory.
// The slave modport is used by axi_zvc_mem_slave; the master modport by whoever drives it.
interface axi_zvc_mem_slave_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ruser;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, ruser, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, ruser, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_zvc_mem_slave.sv
// AXI4 slave line memory with optional zero-value compression on read data.
// Every beat is one full line; FIXED repeats the line, INCR/WRAP step it by one.
// Define AXI_ZVC_MEM_ZVC_EN to flag all-zero lines on ruser (rdata left untouched)
// and count those beats in zvc_hits; otherwise ruser=0 and zvc_hits=0.
module axi_zvc_mem_slave #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axi_zvc_mem_slave_if.slave        s_axi,
    output logic [31:0]               zvc_hits
);
    localparam int OFFS   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LINE_W = ADDR_WIDTH - OFFS;
    localparam logic [LINE_W-1:0] DEPTH_L = LINE_W'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Line storage; deliberately not reset so it maps onto RAM.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t              w_state, w_state_nxt;
    logic [LINE_W-1:0]     w_line;
    logic [7:0]            w_len, w_cnt;
    logic                  w_fixed, w_dec;
    logic                  w_beat, w_oor, w_cnt_last, w_end;

    r_state_t              r_state, r_state_nxt;
    logic [LINE_W-1:0]     r_line;
    logic [7:0]            r_len, r_cnt;
    logic                  r_fixed, r_oor, r_last_beat;
    logic [DATA_WIDTH-1:0] fetch_line;

    // Size fields and sub-line offsets carry no meaning for full-line beats.
    logic unused_fields;
    assign unused_fields = ^{s_axi.awsize, s_axi.arsize,
                             s_axi.awaddr[OFFS-1:0], s_axi.araddr[OFFS-1:0]};

    assign w_beat     = (w_state == W_DATA) && s_axi.wvalid;
    assign w_oor      = (w_line >= DEPTH_L);
    assign w_cnt_last = (w_cnt == w_len);
    assign w_end      = w_cnt_last || s_axi.wlast;

    assign r_oor       = (r_line >= DEPTH_L);
    assign r_last_beat = (r_cnt == r_len);
    assign fetch_line  = mem[r_line[IDX_W-1:0]];

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Write FSM next state and decoded handshake outputs
    always_comb begin
        w_state_nxt   = w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi.awready = 1'b1;
                if (s_axi.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && w_end) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write control: beat counter, error accumulation and B payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi.bid   <= '0;
            s_axi.bresp <= RESP_OKAY;
            w_cnt       <= '0;
            w_dec       <= 1'b0;
        end else if (w_state == W_IDLE && s_axi.awvalid) begin
            s_axi.bid <= s_axi.awid;
            w_cnt     <= '0;
            w_dec     <= 1'b0;
        end else if (w_beat) begin
            w_cnt <= w_cnt + 8'd1;
            w_dec <= w_dec | w_oor;
            if (w_end) begin
                // A wlast/length disagreement outranks an address error.
                if (w_cnt_last != s_axi.wlast) s_axi.bresp <= RESP_SLVERR;
                else if (w_dec || w_oor)       s_axi.bresp <= RESP_DECERR;
                else                           s_axi.bresp <= RESP_OKAY;
            end
        end
    end

    // Write address capture and per-beat line stepping
    always_ff @(posedge clk) begin
        if (w_state == W_IDLE && s_axi.awvalid) begin
            w_line  <= s_axi.awaddr[ADDR_WIDTH-1:OFFS];
            w_len   <= s_axi.awlen;
            w_fixed <= (s_axi.awburst == 2'b00);
        end else if (w_beat && !w_fixed) begin
            w_line <= w_line + LINE_W'(1);
        end
    end

    // Byte-strobed array write; out-of-range beats are dropped
    always_ff @(posedge clk) begin
        if (w_beat && !w_oor) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (s_axi.wstrb[b]) mem[w_line[IDX_W-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Read FSM next state and decoded handshake outputs
    always_comb begin
        r_state_nxt   = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi.arready = 1'b1;
                if (s_axi.arvalid) r_state_nxt = R_FETCH;
            end
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                s_axi.rlast  = r_last_beat;
                if (s_axi.rready) r_state_nxt = r_last_beat ? R_IDLE : R_FETCH;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read address capture and per-beat line stepping
    always_ff @(posedge clk) begin
        if (r_state == R_IDLE && s_axi.arvalid) begin
            r_line  <= s_axi.araddr[ADDR_WIDTH-1:OFFS];
            r_len   <= s_axi.arlen;
            r_fixed <= (s_axi.arburst == 2'b00);
        end else if (r_state == R_DATA && s_axi.rready && !r_last_beat && !r_fixed) begin
            r_line <= r_line + LINE_W'(1);
        end
    end

`ifdef AXI_ZVC_MEM_ZVC_EN
    logic zvc_flag;
    assign s_axi.ruser = zvc_flag;
`else
    assign s_axi.ruser = 1'b0;
    assign zvc_hits    = '0;
`endif

    // Read control: beat counter, R payload register and zero-line detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi.rid   <= '0;
            s_axi.rdata <= '0;
            s_axi.rresp <= RESP_OKAY;
            r_cnt       <= '0;
`ifdef AXI_ZVC_MEM_ZVC_EN
            zvc_flag    <= 1'b0;
`endif
        end else if (r_state == R_IDLE && s_axi.arvalid) begin
            s_axi.rid <= s_axi.arid;
            r_cnt     <= '0;
        end else if (r_state == R_FETCH) begin
            s_axi.rresp <= r_oor ? RESP_DECERR : RESP_OKAY;
`ifdef AXI_ZVC_MEM_ZVC_EN
            // A zero line leaves rdata untoggled; the consumer rebuilds it from ruser.
            if (!r_oor && fetch_line == '0) begin
                zvc_flag <= 1'b1;
            end else begin
                zvc_flag <= 1'b0;
                if (!r_oor) s_axi.rdata <= fetch_line;
            end
`else
            s_axi.rdata <= r_oor ? '0 : fetch_line;
`endif
        end else if (r_state == R_DATA && s_axi.rready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

`ifdef AXI_ZVC_MEM_ZVC_EN
    // Count compressed beats as they are accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                zvc_hits <= '0;
        else if (r_state == R_DATA && s_axi.rready && zvc_flag)    zvc_hits <= zvc_hits + 32'd1;
    end
`endif
endmodule

// File: tb/tb_axi_zvc_mem_slave.sv
// Directed bench for axi_zvc_mem_slave: one task per scenario, inline checks.
module tb_axi_zvc_mem_slave;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int MD = 1024;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] FIXED = 2'b00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] zvc_hits;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    axi_zvc_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_zvc_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(MD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi    (bus),
        .zvc_hits (zvc_hits)
    );

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(k);
        return {16{w}};
    endfunction

    localparam logic [DW/8-1:0] ALL_STRB = '1;

    task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd6;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL aw_timeout: awready=%b required 1", bus.awready); end
        @(posedge clk); #1 bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
        int n;
        @(negedge clk);
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        n = 0;
        while (bus.wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL w_timeout: wready=%b required 1", bus.wready); end
        @(posedge clk); #1 bus.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd6;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL ar_timeout: arready=%b required 1", bus.arready); end
        @(posedge clk); #1 bus.arvalid = 1'b0;
    endtask

    task automatic recv_b(output logic [IW-1:0] id, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL b_timeout: bvalid=%b required 1", bus.bvalid); end
        id = bus.bid; resp = bus.bresp;
        @(posedge clk); #1 bus.bready = 1'b0;
    endtask

    task automatic recv_r(output logic [DW-1:0] data, output logic user, output logic [1:0] resp,
                          output logic last, output logic [IW-1:0] id);
        int n;
        @(negedge clk);
        bus.rready = 1'b1;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL r_timeout: rvalid=%b required 1", bus.rvalid); end
        data = bus.rdata; user = bus.ruser; resp = bus.rresp; last = bus.rlast; id = bus.rid;
        @(posedge clk); #1 bus.rready = 1'b0;
    endtask

    task automatic wr1(input logic [AW-1:0] addr, input logic [DW-1:0] data, output logic [1:0] resp);
        logic [IW-1:0] id;
        send_aw(8'h01, addr, 8'd0, INCR);
        send_w(data, ALL_STRB, 1'b1);
        recv_b(id, resp);
    endtask

    task automatic rd1(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                       output logic user, output logic [1:0] resp);
        logic          last;
        logic [IW-1:0] id;
        send_ar(8'h02, addr, 8'd0, INCR);
        recv_r(data, user, resp, last, id);
    endtask

    task automatic test_reset;
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.awready !== 1'b1) begin n_bad++; $display("FAIL rst_awready: got %b want 1", bus.awready); end
        n_cmp++; if (bus.arready !== 1'b1) begin n_bad++; $display("FAIL rst_arready: got %b want 1", bus.arready); end
        n_cmp++; if ({bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.ruser} !== 5'b0)
            begin n_bad++; $display("FAIL rst_ctrl: got %b want 00000", {bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.ruser}); end
        n_cmp++; if ({bus.bid, bus.bresp, bus.rid, bus.rresp} !== '0)
            begin n_bad++; $display("FAIL rst_ids: got %h want 0", {bus.bid, bus.bresp, bus.rid, bus.rresp}); end
        n_cmp++; if (bus.rdata !== '0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
        n_cmp++; if (zvc_hits !== 32'd0) begin n_bad++; $display("FAIL rst_zvc_hits: got %0d want 0", zvc_hits); end
    endtask

    task automatic test_write_read;
        logic [DW-1:0]   d, got;
        logic [DW/8-1:0] s;
        logic [IW-1:0]   id;
        logic [1:0]      resp;
        logic            user, last;
        d = '0; d[63:32] = 32'hDEADBEEF;
        s = '0; s[7:0] = 8'hF0;
        send_aw(8'h05, 32'h40, 8'd0, INCR);
        n_cmp++; if (bus.wready !== 1'b1) begin n_bad++; $display("FAIL wr_wready_rise: got %b want 1", bus.wready); end
        send_w(d, s, 1'b1);
        n_cmp++; if (bus.bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid_rise: got %b want 1", bus.bvalid); end
        recv_b(id, resp);
        n_cmp++; if (id !== 8'h05) begin n_bad++; $display("FAIL wr_bid: got %h want 05", id); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL wr_bresp: got %b want 00", resp); end
        send_ar(8'h07, 32'h40, 8'd0, INCR);
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_t1: got %b want 0", bus.rvalid); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid_t2: got %b want 1", bus.rvalid); end
        recv_r(got, user, resp, last, id);
        n_cmp++; if (got[63:32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", got[63:32]); end
        n_cmp++; if ({user, last, resp} !== 4'b0100) begin n_bad++; $display("FAIL rd_flags: got user/last/resp %b want 0100", {user, last, resp}); end
        n_cmp++; if (id !== 8'h07) begin n_bad++; $display("FAIL rd_rid: got %h want 07", id); end
    endtask

    task automatic test_zero_line;
        logic [DW-1:0] got;
        logic [1:0]    resp;
        logic          user;
        wr1(32'h200, '0, resp);
        wr1(32'h240, pat(9), resp);
        rd1(32'h240, got, user, resp);
        n_cmp++; if (got !== pat(9)) begin n_bad++; $display("FAIL zero_prev_data: got %h want %h", got[31:0], pat(9) & 32'hFFFFFFFF); end
        rd1(32'h200, got, user, resp);
`ifdef AXI_ZVC_MEM_ZVC_EN
        n_cmp++; if (user !== 1'b1) begin n_bad++; $display("FAIL zero_ruser: got %b want 1", user); end
        n_cmp++; if (got !== pat(9)) begin n_bad++; $display("FAIL zero_rdata_held: got %h want c0de0009", got[31:0]); end
        n_cmp++; if (zvc_hits !== 32'd1) begin n_bad++; $display("FAIL zero_hits: got %0d want 1", zvc_hits); end
`else
        n_cmp++; if (user !== 1'b0) begin n_bad++; $display("FAIL zero_ruser: got %b want 0", user); end
        n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL zero_rdata: got %h want 0", got[31:0]); end
        n_cmp++; if (zvc_hits !== 32'd0) begin n_bad++; $display("FAIL zero_hits: got %0d want 0", zvc_hits); end
`endif
    endtask

    task automatic test_incr_read;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic [DW-1:0] d;
        logic          l, user;
        int            n;
        send_aw(8'h11, 32'h80, 8'd3, INCR);
        for (int k = 0; k < 4; k++) send_w(pat(2 + k), ALL_STRB, (k == 3));
        recv_b(id, resp);
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL incr_wr_bresp: got %b want 00", resp); end
        send_ar(8'h12, 32'h80, 8'd3, INCR);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL incr_timeout: beat %0d rvalid=%b", k, bus.rvalid); end
            d = bus.rdata; l = bus.rlast;
            @(negedge clk);
            n_cmp++; if (bus.rvalid !== 1'b1 || bus.rdata !== d || bus.rlast !== l)
                begin n_bad++; $display("FAIL incr_hold: beat %0d rvalid=%b data %h want %h", k, bus.rvalid, bus.rdata[31:0], d[31:0]); end
            n_cmp++; if (d !== pat(2 + k)) begin n_bad++; $display("FAIL incr_data: beat %0d got %h want line %0d", k, d[31:0], 2 + k); end
            n_cmp++; if (l !== (k == 3)) begin n_bad++; $display("FAIL incr_rlast: beat %0d got %b want %b", k, l, (k == 3)); end
            bus.rready = 1'b1;
            @(posedge clk); #1 bus.rready = 1'b0;
        end
        send_ar(8'h13, 32'h80, 8'd3, FIXED);
        for (int k = 0; k < 4; k++) begin
            recv_r(d, user, resp, l, id);
            n_cmp++; if (d !== pat(2)) begin n_bad++; $display("FAIL fixed_data: beat %0d got %h want c0de0002", k, d[31:0]); end
            n_cmp++; if (l !== (k == 3)) begin n_bad++; $display("FAIL fixed_rlast: beat %0d got %b want %b", k, l, (k == 3)); end
        end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] got;
        logic [1:0]    resp;
        logic          user;
        wr1(32'h0, pat(0), resp);
        wr1(32'h10000, pat(77), resp);
        n_cmp++; if (resp !== 2'b11) begin n_bad++; $display("FAIL oor_bresp: got %b want 11", resp); end
        rd1(32'h0, got, user, resp);
        n_cmp++; if (got !== pat(0)) begin n_bad++; $display("FAIL oor_array_intact: got %h want c0de0000", got[31:0]); end
        rd1(32'h10000, got, user, resp);
        n_cmp++; if (resp !== 2'b11) begin n_bad++; $display("FAIL oor_rresp: got %b want 11", resp); end
        n_cmp++; if (user !== 1'b0) begin n_bad++; $display("FAIL oor_ruser: got %b want 0", user); end
`ifdef AXI_ZVC_MEM_ZVC_EN
        n_cmp++; if (got !== pat(0)) begin n_bad++; $display("FAIL oor_rdata: got %h want c0de0000", got[31:0]); end
`else
        n_cmp++; if (got !== '0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", got[31:0]); end
`endif
    endtask

    task automatic test_early_wlast;
        logic [IW-1:0] id;
        logic [DW-1:0] got;
        logic [1:0]    resp;
        logic          user;
        wr1(32'h300, pat(12), resp);
        send_aw(8'h04, 32'h280, 8'd3, INCR);
        send_w(pat(100), ALL_STRB, 1'b0);
        send_w(pat(101), ALL_STRB, 1'b1);
        n_cmp++; if ({bus.bvalid, bus.wready} !== 2'b10) begin n_bad++; $display("FAIL ewl_close: bvalid/wready %b want 10", {bus.bvalid, bus.wready}); end
        recv_b(id, resp);
        n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL ewl_bresp: got %b want 10", resp); end
        n_cmp++; if (id !== 8'h04) begin n_bad++; $display("FAIL ewl_bid: got %h want 04", id); end
        rd1(32'h280, got, user, resp);
        n_cmp++; if (got !== pat(100)) begin n_bad++; $display("FAIL ewl_line10: got %h want c0de0064", got[31:0]); end
        rd1(32'h2C0, got, user, resp);
        n_cmp++; if (got !== pat(101)) begin n_bad++; $display("FAIL ewl_line11: got %h want c0de0065", got[31:0]); end
        rd1(32'h300, got, user, resp);
        n_cmp++; if (got !== pat(12)) begin n_bad++; $display("FAIL ewl_line12: got %h want c0de000c", got[31:0]); end
    endtask

    task automatic test_collision;
        logic [IW-1:0] id;
        logic [DW-1:0] got;
        logic [1:0]    resp;
        logic          user, last;
        wr1(32'h500, pat(20), resp);
        @(negedge clk);
        bus.awid = 8'h09; bus.awaddr = 32'h500; bus.awlen = 8'd0; bus.awburst = INCR; bus.awvalid = 1'b1;
        bus.arid = 8'h0A; bus.araddr = 32'h500; bus.arlen = 8'd0; bus.arburst = INCR; bus.arvalid = 1'b1;
        bus.wdata = pat(200); bus.wstrb = ALL_STRB; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1 bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        @(posedge clk); #1 bus.wvalid = 1'b0;
        recv_b(id, resp);
        n_cmp++; if ({id, resp} !== {8'h09, 2'b00}) begin n_bad++; $display("FAIL col_b: got id %h resp %b want 09 00", id, resp); end
        recv_r(got, user, resp, last, id);
        n_cmp++; if (got !== pat(20)) begin n_bad++; $display("FAIL col_old_data: got %h want c0de0014", got[31:0]); end
        n_cmp++; if (id !== 8'h0A) begin n_bad++; $display("FAIL col_rid: got %h want 0a", id); end
        rd1(32'h500, got, user, resp);
        n_cmp++; if (got !== pat(200)) begin n_bad++; $display("FAIL col_new_data: got %h want c0de00c8", got[31:0]); end
    endtask

    task automatic test_reset_mid_burst;
        logic [IW-1:0] id;
        logic [DW-1:0] got;
        logic [1:0]    resp;
        logic          user, last;
        int            n;
        send_ar(8'h0B, 32'h80, 8'd3, INCR);
        recv_r(got, user, resp, last, id);
        n = 0;
        @(negedge clk);
        while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin n_cmp++; n_bad++; $display("FAIL rstmid_timeout: rvalid=%b", bus.rvalid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_rvalid: got %b want 0", bus.rvalid); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.arready, bus.rvalid} !== 2'b10) begin n_bad++; $display("FAIL rstmid_idle: arready/rvalid %b want 10", {bus.arready, bus.rvalid}); end
        n_cmp++; if (zvc_hits !== 32'd0) begin n_bad++; $display("FAIL rstmid_hits: got %0d want 0", zvc_hits); end
        send_ar(8'h0C, 32'hC0, 8'd0, INCR);
        recv_r(got, user, resp, last, id);
        n_cmp++; if (got !== pat(3) || last !== 1'b1) begin n_bad++; $display("FAIL rstmid_after: got %h last %b want c0de0003 1", got[31:0], last); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_line();
        test_incr_read();
        test_out_of_range();
        test_early_wlast();
        test_collision();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_zvc_mem_slave.md
# axi_zvc_mem_slave

AXI4 slave memory sitting directly downstream of the CPU-to-AXI adapter. It stores full 512-bit cache lines, serves single-beat and INCR/FIXED bursts on independent read and write channels, and performs zero-value compression (ZVC) on read data. When a fetched line is all zero, the slave asserts `ruser` and leaves `rdata` untoggled. The adapter then generates the zero word locally.

## Interface
- `DATA_WIDTH`, 512: line/beat width in bits (power of two, ≥64)
- `ADDR_WIDTH`, 32: byte address width
- `ID_WIDTH`, 8: AXI ID width
- `MEM_DEPTH`, 1024: number of lines; valid byte range is 0 .. MEM_DEPTH*DATA_WIDTH/8-1
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `s_axi_aw*`: `awid` in ID_WIDTH, `awaddr` in ADDR_WIDTH, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awvalid` in 1, `awready` out 1
- `s_axi_w*`: `wdata` in DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wlast` in 1, `wvalid` in 1, `wready` out 1
- `s_axi_b*`: `bid` out ID_WIDTH, `bresp` out 2, `bvalid` out 1, `bready` in 1
- `s_axi_ar*`: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid` in; `arready` out 1
- `s_axi_r*`: `rid` out ID_WIDTH, `rdata` out DATA_WIDTH, `ruser` out 1 (zero-line flag), `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1
- `zvc_hits` out 32: count of R beats sent with `ruser`=1

## Operation
- **Line index:** `addr >> log2(DATA_WIDTH/8)`. The low offset bits are ignored. `awsize`/`arsize` are ignored, and every beat is one full line.
- **Burst stepping:**
  - FIXED (`burst`=0): every beat uses the same line.
  - INCR and WRAP: the line increments by 1 per beat. WRAP is treated as INCR.
- **Out-of-range line** (index ≥ MEM_DEPTH), evaluated per beat:
  - Reads return `rresp`=DECERR (2'b11), `rdata` unchanged, `ruser`=0.
  - Writes are dropped.
- **Write FSM:** W_IDLE → W_DATA → W_RESP.
  - W_IDLE: `awready`=1. On AW handshake, latch id, line, len and burst; clear beat counter and error flag.
  - W_DATA: `wready`=1. Each W handshake writes bytes where `wstrb`=1 and advances the line.
  - The burst ends on the beat where counter==len or `wlast`=1.
  - Mismatch (`wlast` early, or missing on the final beat): the burst still ends at the first of the two, and the error is SLVERR (2'b10).
  - W_RESP: `bvalid`=1, `bid`=latched id, `bresp`=OKAY, DECERR if any beat was out of range, or SLVERR on a wlast mismatch (SLVERR wins). Hold until `bready`, then go to W_IDLE.
- **Read FSM:** R_IDLE → R_FETCH → R_DATA.
  - R_IDLE: `arready`=1. On AR handshake, latch id, line, len and burst.
  - R_FETCH: read the array into the output register; evaluate the zero test.
  - R_DATA: `rvalid`=1, `rlast`=1 when beat==len. On `rready`: if last, go to R_IDLE; else advance the line and go to R_FETCH.
- **ZVC:** the fetched line is all-zero and in range → `ruser`=1, `rdata` keeps its previous value, and `zvc_hits` increments on that beat's handshake. Otherwise `ruser`=0 and `rdata`=line.
- **Channel independence:** read and write channels run concurrently. If a write and a fetch hit the same line in the same cycle, the fetch returns pre-write data.
- **Array contents:** the array is not reset.

## Timing
- **Reset values:** `awready`=1, `arready`=1 (decoded from idle states); `wready`, `bvalid`, `rvalid`, `rlast`, `ruser` = 0; `bid`, `bresp`, `rid`, `rresp`, `rdata` = 0; `zvc_hits`=0. Both FSMs return to idle.
- **Reset mid-burst:** the transaction is abandoned with no response. Bytes already written remain.
- **Read latency:** AR handshake at cycle T → `rvalid` at T+2. Each later beat appears 2 cycles after the previous R handshake, so a burst sustains 1 beat per 2 cycles.
- **Write handshake:** `wready` rises the cycle after the AW handshake. `bvalid` rises the cycle after the final W handshake.
- **Valid stability:** `rvalid`/`bvalid` and all R/B payload stay stable until handshake.
- **Counter:** `zvc_hits` wraps modulo 2^32.

## Configuration
- `AXI_ZVC_MEM_ZVC_EN` defined: ZVC behaves as described.
- Undefined:
  - `ruser` is tied to 0.
  - `rdata` is always the fetched line (0 for out-of-range).
  - `zvc_hits` stays 0.
  - The zero-detect logic is removed.

## Test plan
- **Write then read:** write `awaddr`=0x40, `wdata`=0xDEADBEEF in bits [63:32], `wstrb`=0xF0, len 0 → `bresp`=OKAY. Read `araddr`=0x40 → `rvalid` at T+2, `rdata`[63:32]=0xDEADBEEF, `ruser`=0, `rlast`=1.
- **Zero line:** read a line written all-zero, after a prior nonzero read left `rdata`=X.
  - With the macro: `ruser`=1, `rdata` still X, `zvc_hits`=1.
  - Without the macro: `ruser`=0, `rdata`=0.
- **INCR read:** len 3 from line 2 with `rready` toggled 1/0 → 4 beats on lines 2..5, payload held while stalled, `rlast` only on the 4th beat. A FIXED burst returns line 2 four times.
- **Out of range:** read/write at line MEM_DEPTH → `rresp`=DECERR, `bresp`=DECERR, and array contents unchanged.
- **Early wlast:** `awlen`=3 with `wlast` on beat 2 → burst closes, `bresp`=SLVERR, 2 lines written.
- **Concurrent collision, plus reset:** concurrent AR and AW to the same line → read returns old data and the write completes. Asserting `rst_n`=0 mid-read-burst → `rvalid`=0 immediately, `arready`=1 after release.
